// File: rtl/eth_10g_st_pkg.sv
// Shared definitions for the 10G MAC TX Avalon-ST timing adapter.
// Holds the default payload width, sideband field offsets and latency limits.
package eth_10g_st_pkg;

  localparam int ST_DATA_WIDTH     = 72;
  localparam int MAX_READY_LATENCY = 4;

  // Sideband layout above the 64-bit data word; opaque to the adapter itself
  localparam int SOP_BIT   = 64;
  localparam int EOP_BIT   = 65;
  localparam int EMPTY_LSB = 66;
  localparam int EMPTY_W   = 3;
  localparam int ERR_BIT   = 69;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/blk_b6e46f_if.sv
// Avalon-ST beat bus: payload, valid and ready bundled for either side of the adapter.
interface blk_b6e46f_if
  import eth_10g_st_pkg::*;
#(
  parameter int DATA_WIDTH = ST_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/eth_10g_st_ready_pipe.sv
// Delays the downstream ready by READY_LATENCY cycles so it lines up with the
// cycle in which the sink actually absorbs a beat; latency 0 is a plain wire.
module eth_10g_st_ready_pipe
  import eth_10g_st_pkg::*;
#(
  parameter int READY_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic out_ready,
  output logic rdy_eff
);

  if (READY_LATENCY < 0 || READY_LATENCY > MAX_READY_LATENCY) begin : g_bad_latency
    $error("READY_LATENCY out of range 0..%0d", MAX_READY_LATENCY);
  end

  if (READY_LATENCY == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign rdy_eff = out_ready;
  end else begin : g_pipe
    logic [READY_LATENCY-1:0] rdy_pipe;

    always_ff @(posedge clk) begin
      if (reset) begin
        rdy_pipe <= '0;
      end else begin
        rdy_pipe[0] <= out_ready;
        for (int i = 1; i < READY_LATENCY; i++) begin
          rdy_pipe[i] <= rdy_pipe[i-1];
        end
      end
    end

    assign rdy_eff = rdy_pipe[READY_LATENCY-1];
  end

endmodule

// File: rtl/blk_b6e46f.sv
// TX timing adapter: ready-latency-0 upstream into a small circular buffer that
// drains into a MAC sink whose ready leads its acceptance by READY_LATENCY cycles.
module blk_b6e46f
  import eth_10g_st_pkg::*;
#(
  parameter int DATA_WIDTH    = ST_DATA_WIDTH,
  parameter int READY_LATENCY = 2,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  blk_b6e46f_if.slave              in_st,
  blk_b6e46f_if.master             out_st,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (!is_pow2(DEPTH)) begin : g_bad_depth_pow2
    $error("DEPTH must be a power of two");
  end
  if (DEPTH < READY_LATENCY + 2) begin : g_bad_depth_size
    $error("DEPTH must be at least READY_LATENCY+2 to absorb in-flight beats");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  rdy_eff;
  logic                  in_rdy;
  logic                  out_vld;
  logic                  wr_en;
  logic                  rd_en;

  eth_10g_st_ready_pipe #(
    .READY_LATENCY (READY_LATENCY)
  ) u_ready_pipe (
    .clk       (clk),
    .reset     (reset),
    .out_ready (out_st.ready),
    .rdy_eff   (rdy_eff)
  );

  // Full blocks writes even if a read happens this cycle: no write-through
  assign in_rdy  = !reset && (count != CNT_W'(DEPTH));
  assign out_vld = !reset && (count != '0) && rdy_eff;
  assign wr_en   = in_st.valid && in_rdy;
  assign rd_en   = out_vld;

  assign in_st.ready  = in_rdy;
  assign out_st.valid = out_vld;
  assign out_st.data  = mem[rd_ptr];
  assign fill_level   = count;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_st.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count <= CNT_W'(DEPTH));

  a_valid_needs_ready: assert property (@(posedge clk)
    out_vld |-> rdy_eff);

endmodule

// File: tb/tb_blk_b6e46f.sv
// Bench for the TX timing adapter at ready latency 2 and 0.
module tb_blk_b6e46f;
  import eth_10g_st_pkg::*;

  localparam int DW    = 72;
  localparam int DEPTH = 4;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ir;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic [2:0]    e_fill;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  blk_b6e46f_if #(.DATA_WIDTH(DW)) in0 ();
  blk_b6e46f_if #(.DATA_WIDTH(DW)) out0 ();
  blk_b6e46f_if #(.DATA_WIDTH(DW)) in2 ();
  blk_b6e46f_if #(.DATA_WIDTH(DW)) out2 ();
  logic [2:0] fill0, fill2;

  blk_b6e46f #(.DATA_WIDTH(DW), .READY_LATENCY(0), .DEPTH(DEPTH)) dut0 (
    .clk(clk), .reset(reset), .in_st(in0), .out_st(out0), .fill_level(fill0));
  blk_b6e46f #(.DATA_WIDTH(DW), .READY_LATENCY(2), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .reset(reset), .in_st(in2), .out_st(out2), .fill_level(fill2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat(input int k);
    return 72'hB0_0000_0000_1111_0000 + 72'(k);
  endfunction

  // Scoreboards: accepted beats queued in order, every out_valid beat popped
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q2[$];
  int rx0 = 0;
  int rx2 = 0;
  logic [1:0] hist2 = '0;

  always @(negedge clk) begin
    if (reset) begin
      q2.delete();
      hist2 <= '0;
    end else begin
      if (out2.valid) begin
        check("rl2_delayed_ready", DW'(hist2[1]), DW'(1));
        if (q2.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rl2_unexpected_beat: got %h expected no beat", out2.data);
        end else begin
          check("rl2_order", out2.data, q2.pop_front());
        end
        rx2 <= rx2 + 1;
      end
      if (in2.valid && in2.ready) q2.push_back(in2.data);
      hist2 <= {hist2[0], out2.ready};
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      q0.delete();
    end else begin
      if (out0.valid) begin
        check("rl0_delayed_ready", DW'(out0.ready), DW'(1));
        if (q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rl0_unexpected_beat: got %h expected no beat", out0.data);
        end else begin
          check("rl0_order", out0.data, q0.pop_front());
        end
        rx0 <= rx0 + 1;
      end
      if (in0.valid && in0.ready) q0.push_back(in0.data);
    end
  end

  logic          ir_s, ov_s;
  logic [DW-1:0] od_s;
  logic [2:0]    fl_s;
  int            sq;

  // One clock cycle: drive at posedge+1, sample at posedge+4, advance
  task automatic cyc(input int sel, input logic iv, input logic [DW-1:0] d, input logic ordy);
    if (sel == 0) begin
      in0.valid = iv; in0.data = d; out0.ready = ordy;
    end else begin
      in2.valid = iv; in2.data = d; out2.ready = ordy;
    end
    #3;
    if (sel == 0) begin
      ir_s = in0.ready; ov_s = out0.valid; od_s = out0.data; fl_s = fill0;
    end else begin
      ir_s = in2.ready; ov_s = out2.valid; od_s = out2.data; fl_s = fill2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic iv, input logic ordy);
    cyc(2, iv, beat(sq), ordy);
    if (iv && ir_s) sq++;
  endtask

  vec_t tbl[$];
  int   ef[5]  = '{1, 2, 3, 4, 4};
  int   eir[5] = '{1, 1, 1, 0, 0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d6;
    logic [DW-1:0] pk;
    logic          tog;
    int            rxb, sqb, cycles, got;

    d6 = 72'h00_DEADBEEF_CAFEF00D;

    // Idle, then test 6 single beat, then test 1 ten-beat packet with sop/eop marked
    for (int c = 0; c < 18; c++) begin
      vec_t v;
      v.iv = 1'b0; v.d = '0; v.ordy = 1'b1; v.e_ir = 1'b1;
      v.e_ov = 1'b0; v.e_od = '0; v.e_fill = 3'd0;
      if (c == 3) begin v.iv = 1'b1; v.d = d6; end
      if (c == 4) begin v.e_ov = 1'b1; v.e_od = d6; v.e_fill = 3'd1; end
      if (c >= 6 && c <= 15) begin
        pk = beat(c - 6);
        pk[SOP_BIT] = (c == 6);
        pk[EOP_BIT] = (c == 15);
        v.iv = 1'b1; v.d = pk;
      end
      if (c >= 7 && c <= 16) begin
        pk = beat(c - 7);
        pk[SOP_BIT] = (c == 7);
        pk[EOP_BIT] = (c == 16);
        v.e_ov = 1'b1; v.e_od = pk; v.e_fill = 3'd1;
      end
      tbl.push_back(v);
    end

    reset = 1'b1;
    in0.valid = 1'b0; in0.data = '0; out0.ready = 1'b1;
    in2.valid = 1'b0; in2.data = '0; out2.ready = 1'b1;
    @(posedge clk);
    #1;
    cyc(2, 1'b0, '0, 1'b1);
    check("rst_in_ready", DW'(ir_s), DW'(0));
    check("rst_out_valid", DW'(ov_s), DW'(0));
    check("rst_fill2", DW'(fl_s), DW'(0));
    cyc(2, 1'b0, '0, 1'b1);
    check("rst_fill0", DW'(fill0), DW'(0));
    check("rst_in_ready0", DW'(in0.ready), DW'(0));
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(2, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      check($sformatf("vec%0d_in_ready", i), DW'(ir_s), DW'(tbl[i].e_ir));
      check($sformatf("vec%0d_out_valid", i), DW'(ov_s), DW'(tbl[i].e_ov));
      check($sformatf("vec%0d_fill", i), DW'(fl_s), DW'(tbl[i].e_fill));
      if (tbl[i].e_ov) check($sformatf("vec%0d_out_data", i), od_s, tbl[i].e_od);
    end

    // Test 2: steady stream, out_ready dropped at T
    sq = 100; sqb = sq; rxb = rx2;
    repeat (4) step2(1'b1, 1'b1);
    step2(1'b1, 1'b0);
    check("t2_ov_T", DW'(ov_s), DW'(1));
    step2(1'b1, 1'b0);
    check("t2_ov_T1", DW'(ov_s), DW'(1));
    for (int k = 0; k < 5; k++) begin
      step2(1'b1, 1'b0);
      check($sformatf("t2_ov_T%0d", k + 2), DW'(ov_s), DW'(0));
      check($sformatf("t2_fill_T%0d", k + 2), DW'(fl_s), DW'(ef[k]));
      check($sformatf("t2_in_ready_T%0d", k + 2), DW'(ir_s), DW'(eir[k]));
    end

    // Test 3: out_ready reasserted at U while full
    step2(1'b1, 1'b1);
    check("t3_ov_U", DW'(ov_s), DW'(0));
    step2(1'b1, 1'b1);
    check("t3_ov_U1", DW'(ov_s), DW'(0));
    check("t3_ir_U1", DW'(ir_s), DW'(0));
    step2(1'b1, 1'b1);
    check("t3_ov_U2", DW'(ov_s), DW'(1));
    check("t3_ir_U2", DW'(ir_s), DW'(0));
    check("t3_fill_U2", DW'(fl_s), DW'(4));
    step2(1'b1, 1'b1);
    check("t3_ir_U3", DW'(ir_s), DW'(1));
    check("t3_fill_U3", DW'(fl_s), DW'(3));
    check("t3_ov_U3", DW'(ov_s), DW'(1));
    repeat (8) step2(1'b0, 1'b1);
    check("t3_drained_fill", DW'(fill2), DW'(0));
    check("t3_no_loss", DW'(rx2 - rxb), DW'(sq - sqb));

    // Test 5: reset with three beats buffered
    sq = 200;
    repeat (2) step2(1'b0, 1'b0);
    repeat (3) begin
      step2(1'b1, 1'b0);
      check("t5_fill_ir", DW'(ir_s), DW'(1));
    end
    step2(1'b0, 1'b0);
    check("t5_fill3", DW'(fl_s), DW'(3));
    check("t5_ov_held", DW'(ov_s), DW'(0));
    reset = 1'b1;
    step2(1'b0, 1'b1);
    reset = 1'b0;
    step2(1'b0, 1'b1);
    check("t5_fill_after", DW'(fl_s), DW'(0));
    check("t5_ov_after", DW'(ov_s), DW'(0));
    check("t5_ir_after", DW'(ir_s), DW'(1));
    for (int k = 0; k < 5; k++) begin
      step2(1'b0, 1'b1);
      check($sformatf("t5_stale_ov%0d", k), DW'(ov_s), DW'(0));
    end

    // Test 4: toggling out_ready, random in_valid, both latencies
    for (int pass = 0; pass < 2; pass++) begin
      int sel;
      sel = (pass == 0) ? 2 : 0;
      in0.valid = 1'b0;
      in2.valid = 1'b0;
      rxb = (sel == 0) ? rx0 : rx2;
      tog = 1'b0;
      cycles = 0;
      got = 0;
      while (got < 1000 && cycles < 20000) begin
        tog = ~tog;
        cyc(sel, 1'($urandom_range(0, 1)), {8'($urandom), $urandom, $urandom}, tog);
        cycles++;
        got = ((sel == 0) ? rx0 : rx2) - rxb;
      end
      check($sformatf("t4_rl%0d_beats", sel), DW'(got >= 1000), DW'(1));
      repeat (20) cyc(sel, 1'b0, '0, 1'b1);
      check($sformatf("t4_rl%0d_left", sel), DW'((sel == 0) ? q0.size() : q2.size()), DW'(0));
      check($sformatf("t4_rl%0d_fill", sel), DW'((sel == 0) ? fill0 : fill2), DW'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/blk_b6e46f.md
Name: sonic_v1_15_eth_10g_eth_10g_mac_tx_st_timing_adapter_ready_latency

Overview:
TX-direction Avalon-ST timing adapter placed between the user/packet-generator source and the 10G MAC TX sink.
- Upstream side: ready-latency-0 handshake (in_ready/in_valid).
- Downstream MAC TX sink: asserts out_ready READY_LATENCY cycles before it can absorb a beat.
- A small circular buffer absorbs the beats already in flight when the MAC backpressures, so upstream is never dropped and the MAC readyLatency contract is never violated.

Parameters:
- DATA_WIDTH, 72, payload width (64 data + sop/eop/empty/error sideband, opaque to this block).
- READY_LATENCY, 2, downstream ready latency in cycles; legal range 0..4.
- DEPTH, 4, buffer entries; power of two, must be >= READY_LATENCY+2.

Ports:
- clk, input, 1, single clock for all logic.
- reset, input, 1, synchronous, active-high reset.
- in_data, input, DATA_WIDTH, upstream payload.
- in_valid, input, 1, upstream beat valid.
- in_ready, output, 1, adapter can accept a beat this cycle (readyLatency 0).
- out_data, output, DATA_WIDTH, payload to MAC TX.
- out_valid, output, 1, beat presented to MAC TX.
- out_ready, input, 1, MAC TX ready with READY_LATENCY cycles of latency.
- fill_level, output, $clog2(DEPTH)+1, current buffer occupancy.

Behaviour:
- Reset (sampled on posedge clk while reset=1):
  - wr_ptr, rd_ptr and count are cleared to 0; the ready pipe is cleared to 0.
  - in_ready=0 while reset is high; out_valid=0; fill_level=0; out_data is don't-care.
  - First cycle after reset deasserts: in_ready=1, out_valid=0.
- Ready pipe:
  - rdy_eff = out_ready delayed by READY_LATENCY register stages.
  - For READY_LATENCY=0, rdy_eff = out_ready combinationally.
- Write:
  - in_ready = (count != DEPTH).
  - Accept when in_valid && in_ready; store in_data at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
- Read:
  - out_valid = (count != 0) && rdy_eff; out_data = mem[rd_ptr].
  - A transfer occurs whenever out_valid=1. No downstream ready check at that cycle, per readyLatency semantics.
  - rd_ptr increments modulo DEPTH on each transfer.
- Count: +1 on write only, -1 on read only, unchanged on simultaneous write and read. fill_level = count.
- Latency: no bypass path. An accepted beat appears on out_valid no earlier than the next cycle, and only if rdy_eff is 1 then.
- Full:
  - in_ready=0.
  - A simultaneous read in the same cycle does not re-open in_ready until the next cycle; no write-through at full.
- Empty: out_valid=0 regardless of rdy_eff. Empty-cycle ready slots are lost, which is legal.
- Backpressure sizing: DEPTH >= READY_LATENCY+2 guarantees no loss. Upstream may keep writing while out_ready deasserts; the MAC still accepts READY_LATENCY more beats.
- Reset mid-operation: buffered beats are discarded and the ready pipe is flushed. No partial-packet repair; the upstream must also be reset.
- Simulation-only assertions:
  - count never exceeds DEPTH.
  - out_valid is never high while rdy_eff is low.
  - DEPTH/READY_LATENCY legality is checked at elaboration.

Decomposition:
- Shared package eth_10g_st_pkg holds:
  - DATA_WIDTH default 72.
  - Sideband field offsets (sop, eop, empty[2:0], error) for bench decode.
  - MAX_READY_LATENCY=4.
- One sub-module, eth_10g_st_ready_pipe: parameterised READY_LATENCY shift register producing rdy_eff, with a pass-through for 0.
- The buffer is inline (register array). No vendor FIFO.

Test Plan:
1. Reset, then out_ready held 1, READY_LATENCY=2, a 10-beat packet streamed with in_valid=1 -> in_ready=1 throughout. The first out_valid arrives one cycle after the first accept, and all 10 beats exit in order.
2. Steady stream, then out_ready dropped at cycle T -> out_valid continues through T+1, is 0 from T+2 on, and fill_level climbs to 4 with in_ready=0. No beat is lost.
3. Buffer full (fill_level=4), then out_ready reasserted at cycle T -> first out_valid at T+2, in_ready returns to 1 at T+3, and data order is preserved across the wr_ptr/rd_ptr wrap.
4. out_ready toggled every cycle with in_valid random (50%) over 1000 beats, for READY_LATENCY=0 and for READY_LATENCY=2 -> scoreboard matches exactly, and out_valid is never high while delayed out_ready is 0.
5. reset asserted for 1 cycle with fill_level=3 -> next cycle fill_level=0, out_valid=0, in_ready=1. The stale beats never appear on out_data with out_valid=1.
6. Empty buffer with rdy_eff=1, and a single beat 0x00_DEADBEEF_CAFEF00D accepted at cycle T -> out_valid=1 at T+1 with identical out_data, and fill_level returns to 0 at T+2.
